// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

    // Mode encoding captured with START
    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

    // Control FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of digit cycles per operation
    function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Width of a counter indexing 0..ndig-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit slice of the serial adder: ripple add with B inverted in subtract mode.
module addsub_digit
    import addsub_pkg::*;
#(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT-1:0] bx;
    logic [DIGIT:0]   c;

    // Ripple chain across the digit; c[i] is the carry into bit i
    always_comb begin
        bx   = (mode == MODE_ADD) ? b : ~b;
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor with START/BUSY/DONE handshake and C/V/Z/N flags.
// Optional build macro ADDSUB_SATURATE_EN: clamp S to the signed limit on overflow.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int unsigned NDIG = num_digits(WIDTH, DIGIT);
    localparam int unsigned CW   = cnt_width(NDIG);

    state_t state, state_next;

    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       a_sr;
    logic [WIDTH-1:0]       b_sr;
    logic [WIDTH-1:0]       res_sr;
    logic                   mode_r;
    logic                   carry_r;

    logic                   accept;
    logic                   last_digit;

    logic [DIGIT-1:0]       dsum;
    logic                   dcout;
    logic                   dcmsb;
    logic                   v_raw;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic [WIDTH-1:0]       s_final;

    // Current digit: low DIGIT bits of the operand shift registers
    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_sr[DIGIT-1:0]),
        .b    (b_sr[DIGIT-1:0]),
        .mode (mode_r),
        .cin  (carry_r),
        .sum  (dsum),
        .cout (dcout),
        .cmsb (dcmsb)
    );

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_digit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CW'(NDIG - 1)) begin
                    last_digit = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; BUSY mirrors the state it is entering
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
        end else begin
            state <= state_next;
            BUSY  <= (state_next == ST_RUN);
        end
    end

    // New digit enters at the top of the result shift register
    always_comb begin
        res_cat  = {dsum, res_sr};
        res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
        v_raw    = dcout ^ dcmsb;
    end

`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow the raw sign is the inverse of A's sign, so it selects the limit
    always_comb begin
        s_final = res_next;
        if (v_raw) begin
            s_final = res_next[WIDTH-1] ? SAT_MAX : SAT_MIN;
        end
    end
`else
    // Wrapping result
    always_comb begin
        s_final = res_next;
    end
`endif

    // Operand capture, digit iteration and result/flag update
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            mode_r  <= 1'b0;
            carry_r <= 1'b0;
            DONE    <= 1'b0;
            S       <= '0;
            C       <= 1'b0;
            V       <= 1'b0;
            Z       <= 1'b0;
            N       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (accept) begin
                a_sr    <= A;
                b_sr    <= B;
                mode_r  <= M;
                carry_r <= (M == MODE_SUB);
                res_sr  <= '0;
                cnt     <= '0;
            end else if (state == ST_RUN) begin
                a_sr    <= a_sr >> DIGIT;
                b_sr    <= b_sr >> DIGIT;
                carry_r <= dcout;
                res_sr  <= res_next;
                cnt     <= cnt + CW'(1);
                if (last_digit) begin
                    S    <= s_final;
                    C    <= dcout;
                    V    <= v_raw;
                    Z    <= (s_final == '0);
                    N    <= s_final[WIDTH-1];
                    DONE <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=16, DIGIT=4); honours ADDSUB_SATURATE_EN.
module tb_addsub_serial;

    localparam int unsigned W    = 16;
    localparam int unsigned NDIG = 4;
`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } res_t;

    typedef struct packed {
        logic         m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        res_t         exp;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         M = 1'b0;
    logic         BUSY, DONE, C, V, Z, N;
    logic [W-1:0] S;

    res_t sb_q[$];
    vec_t vecs[$];
    int   done_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;
    res_t mon_exp;

    always #5 CLK = ~CLK;

    addsub_serial #(.WIDTH(W), .DIGIT(NDIG)) dut (
        .CLK (CLK), .RST_N (RST_N), .START (START), .A (A), .B (B), .M (M),
        .BUSY (BUSY), .DONE (DONE), .S (S), .C (C), .V (V), .Z (Z), .N (N)
    );

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Independent reference: full-width add, overflow from operand/result signs
    function automatic res_t model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t         r;
        logic [W:0]   full;
        logic [W-1:0] bx;
        bx   = m ? b : ~b;
        full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, ~m};
        r.c  = full[W];
        r.v  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
        r.s  = full[W-1:0];
        if (SAT && r.v) r.s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        r.z  = (r.s == '0);
        r.n  = r.s[W-1];
        return r;
    endfunction

    task automatic add_vec(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] s, input logic c, input logic v,
                           input logic z, input logic n);
        vec_t t;
        t.m = m; t.a = a; t.b = b;
        t.exp.s = s; t.exp.c = c; t.exp.v = v; t.exp.z = z; t.exp.n = n;
        vecs.push_back(t);
    endtask

    // Called at a negedge: waits for idle, presents one START, returns one negedge later
    task automatic start_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b, input res_t exp);
        int g = 0;
        while (BUSY && g < 50) begin
            @(negedge CLK);
            g++;
        end
        if (BUSY) begin
            checks++; errors++;
            $display("FAIL busy_timeout got BUSY=1 expected BUSY=0 within 50 cycles");
        end
        A = a; B = b; M = m; START = 1'b1;
        sb_q.push_back(exp);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb_q.size() != 0 && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Scoreboard: compare every DONE against the oldest expected result
    always @(negedge CLK) begin
        cyc++;
        if (DONE) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            check("done_single_pulse", W'(prev_done), W'(1'b0));
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done got DONE=1 expected no pending op");
            end else begin
                mon_exp = sb_q.pop_front();
                check("S", S, mon_exp.s);
                check("C", W'(C), W'(mon_exp.c));
                check("V", W'(V), W'(mon_exp.v));
                check("Z", W'(Z), W'(mon_exp.z));
                check("N", W'(N), W'(mon_exp.n));
            end
        end
        prev_done = DONE;
    end

    initial begin
        int   lat;
        int   d0;
        int   n0;
        res_t r;
        logic [W-1:0] ra, rb;
        logic         rm;

        add_vec(1'b1, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0, !SAT);
        add_vec(1'b0, 16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0, SAT);
        add_vec(1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec(1'b1, 16'h8000, 16'h8000, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT, SAT);
        add_vec(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 16'h7FFF, 16'hFFFF, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0, !SAT);
        add_vec(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset state
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_BUSY", W'(BUSY), '0);
        check("rst_DONE", W'(DONE), '0);
        check("rst_S", S, '0);
        check("rst_flags", W'({C, V, Z, N}), '0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Latency and no partial sums on S
        start_op(vecs[0].m, vecs[0].a, vecs[0].b, vecs[0].exp);
        check("busy_after_start", W'(BUSY), W'(1'b1));
        lat = 1;
        while (!DONE && lat < 20) begin
            if (lat == 3) check("S_hold_during_run", S, '0);
            @(negedge CLK);
            lat++;
        end
        check("latency", W'(lat), W'(NDIG + 1));
        @(negedge CLK);

        // Table, issued back-to-back
        n0 = done_cyc.size();
        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].exp);
        end
        wait_drain();
        for (int i = n0 + 1; i < done_cyc.size(); i++) begin
            check("b2b_period", W'(done_cyc[i] - done_cyc[i-1]), W'(NDIG + 1));
        end

        // START during BUSY is ignored
        d0 = done_cnt;
        start_op(1'b0, 16'h1234, 16'h1234, model(1'b0, 16'h1234, 16'h1234));
        @(negedge CLK);
        A = 16'hFFFF; B = 16'h0001; M = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_drain();
        repeat (10) @(negedge CLK);
        check("ignored_start_dones", W'(done_cnt - d0), W'(1));

        // Leave a non-zero result with N=1, then abort mid-operation
        start_op(1'b0, 16'h0005, 16'h0007, model(1'b0, 16'h0005, 16'h0007));
        wait_drain();
        @(negedge CLK);
        d0 = done_cnt;
        start_op(1'b1, 16'h1234, 16'h0FCD, model(1'b1, 16'h1234, 16'h0FCD));
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check("abort_BUSY", W'(BUSY), '0);
        check("abort_DONE", W'(DONE), '0);
        check("abort_S", S, '0);
        check("abort_flags", W'({C, V, Z, N}), '0);
        RST_N = 1'b1;
        void'(sb_q.pop_back());
        repeat (8) @(negedge CLK);
        check("abort_no_done", W'(done_cnt - d0), '0);
        start_op(1'b1, 16'h1234, 16'h0FCD, model(1'b1, 16'h1234, 16'h0FCD));
        wait_drain();
        check("post_abort_done", W'(done_cnt - d0), W'(1));

        // Random operands against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            r  = model(rm, ra, rb);
            start_op(rm, ra, rb, r);
        end
        wait_drain();
        repeat (4) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
